// File: rtl/edge_result_pkg.sv
// Shared constants for the edge-result FIFO bridge.
// Status word bit positions and field widths.
package edge_result_pkg;

  localparam int STATUS_W = 32;
  localparam int FILL_W   = 5;
  localparam int POPCNT_W = 15;

  localparam int ST_DATA_LSB   = 0;
  localparam int ST_FILL_LSB   = 8;
  localparam int ST_OVF        = 13;
  localparam int ST_EMPTY      = 14;
  localparam int ST_FULL       = 15;
  localparam int ST_POPCNT_LSB = 16;
  localparam int ST_ACK        = 31;

endpackage

// File: rtl/edge_result_sync_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers, fill counter.
// Ports: push/din in, pop in, head/fill/full/empty out.
module edge_result_sync_fifo
  import edge_result_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [FILL_W-1:0] fill,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (fill == FILL_W'(DEPTH));
  assign empty   = (fill == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/edge_result_fifo_bridge.sv
// FIFO bridge from edge-detector results to a polled 32-bit input PIO.
// Ports: res_valid/res_data/res_ready in, ack_toggle pop, status_word out.
// Option: EDGE_RESULT_OVF_EN drops pushes when full and flags overflow.
module edge_result_fifo_bridge
  import edge_result_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                res_valid,
  input  logic [DATA_W-1:0]   res_data,
  output logic                res_ready,
  input  logic                ack_toggle,
  output logic [STATUS_W-1:0] status_word
);

  logic [DATA_W-1:0]   head;
  logic [FILL_W-1:0]   fill;
  logic                full;
  logic                empty;
  logic                ack_q;
  logic                ack_seen;
  logic                pop_req;
  logic                pop;
  logic                push;
  logic                ovf_bit;
  logic [POPCNT_W-1:0] pop_cnt;
  logic [STATUS_W-1:0] st;

  // A toggle is consumed even when empty; only a real pop counts.
  assign pop_req = ack_q ^ ack_seen;
  assign pop     = pop_req && !empty;
  assign push    = res_valid && !full;

`ifdef EDGE_RESULT_OVF_EN
  logic ovf;
  logic drop;

  assign res_ready = 1'b1;
  assign drop      = res_valid && full;
  assign ovf_bit   = ovf;

  // A drop on the same cycle as a pop still flags overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
    else if (pop)  ovf <= 1'b0;
  end
`else
  assign res_ready = !full;
  assign ovf_bit   = 1'b0;
`endif

  edge_result_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .din    (res_data),
    .pop    (pop),
    .head   (head),
    .fill   (fill),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    st = '0;
    if (!empty) st[ST_DATA_LSB +: DATA_W] = head;
    st[ST_FILL_LSB +: FILL_W]     = fill;
    st[ST_OVF]                    = ovf_bit;
    st[ST_EMPTY]                  = empty;
    st[ST_FULL]                   = full;
    st[ST_POPCNT_LSB +: POPCNT_W] = pop_cnt;
    st[ST_ACK]                    = ack_seen;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q       <= 1'b0;
      ack_seen    <= 1'b0;
      pop_cnt     <= '0;
      status_word <= STATUS_W'(1) << ST_EMPTY;
    end else begin
      ack_q       <= ack_toggle;
      status_word <= st;
      if (pop_req) ack_seen <= ack_q;
      if (pop)     pop_cnt  <= pop_cnt + POPCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_edge_result_fifo_bridge.sv
// Directed testbench for edge_result_fifo_bridge.
// Hand-computed status words checked after each step.
module tb_edge_result_fifo_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = '0;
  logic        res_ready;
  logic        ack = 1'b0;
  logic [31:0] status_word;

  int n_vec = 0;
  int n_err = 0;

  edge_result_fifo_bridge #(
    .DATA_W(8),
    .DEPTH (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .ack_toggle (ack),
    .status_word(status_word)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  initial begin
    step(); step(); step();
    reset_n = 1'b1;
    check("reset_word", status_word, 32'h0000_4000);

    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_word", status_word, 32'h0000_4000);
      check("idle_ready", {31'b0, res_ready}, 32'd1);
    end

    // two pushes then one pop
    res_valid = 1'b1;
    res_data  = 8'hA5;
    step();
    res_data  = 8'h3C;
    step();
    res_valid = 1'b0;
    step();
    check("two_push", status_word, 32'h0000_02A5);
    ack = 1'b1;
    step();
    step();
    check("pop_lat", status_word, 32'h0000_02A5);
    step();
    check("pop_one", status_word, 32'h8001_013C);
    ack = 1'b0;
    step(); step(); step();
    check("pop_two", status_word, 32'h0002_4000);

`ifndef EDGE_RESULT_OVF_EN
    // fill to 16, hold 17th, pop frees one slot
    res_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      res_data = 8'(i);
      step();
    end
    res_data = 8'h10;
    check("full_ready", {31'b0, res_ready}, 32'd0);
    step();
    check("full_word", status_word, 32'h0002_9000);
    ack = 1'b1;
    step();
    step();
    check("pop_ready", {31'b0, res_ready}, 32'd1);
    step();
    check("full_pop", status_word, 32'h8003_0F01);
    res_valid = 1'b0;
    check("refull_ready", {31'b0, res_ready}, 32'd0);
    step();
    check("refull_word", status_word, 32'h8003_9001);
`endif

    // asynchronous reset mid-stream
    ack = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst", status_word, 32'h0000_4000);
    check("async_rdy", {31'b0, res_ready}, 32'd1);
    step(); step();
    reset_n = 1'b1;
    step();
    check("post_rst", status_word, 32'h0000_4000);

    // toggle on empty FIFO, then toggle with a push
    ack = 1'b1;
    step(); step(); step();
    check("empty_pop", status_word, 32'h8000_4000);
    ack = 1'b0;
    step();
    res_valid = 1'b1;
    res_data  = 8'h77;
    step();
    res_valid = 1'b0;
    step();
    check("empty_push", status_word, 32'h0000_0177);

    // pop counter wrap, FIFO kept non-empty
    res_valid = 1'b1;
    res_data  = 8'h5A;
    for (int k = 0; k < 32767; k++) begin
      ack = ~ack;
      step();
      step();
    end
    step();
    check("cnt_max", {17'b0, status_word[30:16]}, 32'h0000_7FFF);
    check("cnt_max_ack", {31'b0, status_word[31]}, 32'd1);
    ack = ~ack;
    step(); step(); step();
    check("cnt_wrap", {17'b0, status_word[30:16]}, 32'd0);
    check("cnt_wrap_ack", {31'b0, status_word[31]}, 32'd0);
    res_valid = 1'b0;

`ifdef EDGE_RESULT_OVF_EN
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    res_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      res_data = 8'(i);
      step();
    end
    check("ovf_ready", {31'b0, res_ready}, 32'd1);
    res_data = 8'hFF;
    step();
    res_valid = 1'b0;
    step();
    check("ovf_set", status_word, 32'h0000_B000);
    ack = 1'b1;
    step(); step(); step();
    check("ovf_clr", status_word, 32'h8001_0F01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
